cdb_arbiter: RTL and testbench

Collects completed results from the functional units and drives them onto the Common Data Bus as its master. Each FU writes into a private result queue. Every cycle, up to `CDB_LANES` queue heads are granted and broadcast on the registered CDB lanes. The reservation stations, register status table and ROB consume those lanes as CDB slaves. Per-FU back-pressure stalls an FU when its queue is full.

---
 rtl/cdb_arbiter_pkg.sv | 31 +++
 rtl/cdb_if.sv | 15 +
 rtl/cdb_result_fifo.sv | 56 +++++
 rtl/cdb_arbiter.sv | 149 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: result payload and width constants.
// The width macros normally come from the core's defines file; defaults are
// provided so the block elaborates standalone.

`ifndef NUM_OF_FU
`define NUM_OF_FU 4
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package cdb_arbiter_pkg;

    localparam int unsigned PHYS_REG_W = `PHYSICAL_REG_NUM_WIDTH;
    localparam int unsigned REG_VAL_W  = `REG_VAL_WIDTH;
    localparam int unsigned ROB_TAG_W  = `ROB_SIZE_WIDTH;

    // One completed result waiting for broadcast
    typedef struct packed {
        logic [PHYS_REG_W-1:0] dst_addr;
        logic [REG_VAL_W-1:0]  val;
        logic [ROB_TAG_W-1:0]  tag;
    } cdb_result_t;

endpackage

// File: rtl/cdb_if.sv
// Common Data Bus: per-lane valid, destination register and value.
// master: the CDB arbiter; slave: RS, register status table, ROB.

interface CDB_IF
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned LANES = `NUM_OF_FU
);
    logic [LANES-1:0]                 valid;
    logic [LANES-1:0][PHYS_REG_W-1:0] register_addr;
    logic [LANES-1:0][REG_VAL_W-1:0]  register_val;

    modport master (output valid, register_addr, register_val);
    modport slave  (input  valid, register_addr, register_val);
endinterface

// File: rtl/cdb_result_fifo.sv
// Per-FU result queue feeding the CDB arbiter.
// Ports: clk, reset (async, active-low), push/push_data (enqueue),
//        pop (dequeue head), head (current oldest entry), count, full, empty.
// Callers must not push when full or pop when empty.

module cdb_result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter  int unsigned QUEUE_DEPTH = 2,
    localparam int unsigned PTR_W       = $clog2(QUEUE_DEPTH),
    localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  cdb_result_t      push_data,
    input  logic             pop,
    output cdb_result_t      head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    cdb_result_t       mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Payload storage needs no reset; only pointers/count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(QUEUE_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// CDB master: queues FU results and broadcasts up to CDB_LANES per cycle.
// Ports: clk, reset (async, active-low); fu_res_* result inputs per FU and
//        fu_res_ready back-pressure; cdb_ready from the consumers; cdb_if lanes
//        (valid/register_addr/register_val) plus cdb_tag; pending_cnt = queued total.
// Config: CDB_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise
//         fixed priority with FU0 highest.

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int unsigned FU_NUM      = `NUM_OF_FU,
    parameter  int unsigned CDB_LANES   = `NUM_OF_FU,
    parameter  int unsigned QUEUE_DEPTH = 2,
    localparam int unsigned FU_IDX_W    = (FU_NUM > 1) ? $clog2(FU_NUM) : 1,
    localparam int unsigned LANE_IDX_W  = (CDB_LANES > 1) ? $clog2(CDB_LANES) : 1,
    localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH) + 1,
    localparam int unsigned PEND_W      = $clog2(FU_NUM * QUEUE_DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [FU_NUM-1:0]                    fu_res_valid,
    input  logic [FU_NUM-1:0]                    fu_res_reg_write,
    input  logic [FU_NUM-1:0][PHYS_REG_W-1:0]    fu_res_dst_addr,
    input  logic [FU_NUM-1:0][REG_VAL_W-1:0]     fu_res_val,
    input  logic [FU_NUM-1:0][ROB_TAG_W-1:0]     fu_res_tag,
    output logic [FU_NUM-1:0]                    fu_res_ready,
    input  logic                                 cdb_ready,
    CDB_IF.master                                cdb_if,
    output logic [CDB_LANES-1:0][ROB_TAG_W-1:0]  cdb_tag,
    output logic [PEND_W-1:0]                    pending_cnt
);

    cdb_result_t          fu_result  [FU_NUM];
    cdb_result_t          fifo_head  [FU_NUM];
    logic [CNT_W-1:0]     fifo_count [FU_NUM];
    logic [FU_NUM-1:0]    fifo_full;
    logic [FU_NUM-1:0]    fifo_empty;
    logic [FU_NUM-1:0]    push;
    logic [FU_NUM-1:0]    grant;
    logic [CDB_LANES-1:0] lane_vld;
    logic [FU_IDX_W-1:0]  lane_fu [CDB_LANES];
    logic [PEND_W-1:0]    pend_next;
    int                   pos;
    int                   n_grant;

    // Ready depends only on the registered count, never on this cycle's pop
    assign fu_res_ready = ~fifo_full;

    // Non-writing results are acknowledged but never enter a queue
    assign push = fu_res_valid & fu_res_ready & fu_res_reg_write;

    // One result queue per FU
    for (genvar i = 0; i < int'(FU_NUM); i++) begin : g_fifo
        assign fu_result[i] = '{dst_addr: fu_res_dst_addr[i],
                                val:      fu_res_val[i],
                                tag:      fu_res_tag[i]};

        cdb_result_fifo #(
            .QUEUE_DEPTH (QUEUE_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[i]),
            .push_data (fu_result[i]),
            .pop       (grant[i]),
            .head      (fifo_head[i]),
            .count     (fifo_count[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i])
        );
    end

`ifdef CDB_ARB_ROUND_ROBIN_EN
    logic [FU_IDX_W-1:0] rr_ptr;
    logic [FU_IDX_W-1:0] last_fu;

    // Next search starts just after the last FU granted this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (last_fu == FU_IDX_W'(FU_NUM - 1)) ? '0 : last_fu + FU_IDX_W'(1);
        end
    end
`endif

    // Grant up to CDB_LANES non-empty heads, packing them onto lanes in grant order
    always_comb begin
        grant    = '0;
        lane_vld = '0;
        lane_fu  = '{default: '0};
        n_grant  = 0;
        pos      = 0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
        last_fu  = rr_ptr;
`endif
        if (cdb_ready) begin
            for (int j = 0; j < int'(FU_NUM); j++) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
                pos = int'(rr_ptr) + j;
                if (pos >= int'(FU_NUM)) begin
                    pos = pos - int'(FU_NUM);
                end
`else
                pos = j;
`endif
                if (!fifo_empty[FU_IDX_W'(pos)] && (n_grant < int'(CDB_LANES))) begin
                    grant[FU_IDX_W'(pos)]           = 1'b1;
                    lane_vld[LANE_IDX_W'(n_grant)] = 1'b1;
                    lane_fu[LANE_IDX_W'(n_grant)]  = FU_IDX_W'(pos);
`ifdef CDB_ARB_ROUND_ROBIN_EN
                    last_fu = FU_IDX_W'(pos);
`endif
                    n_grant = n_grant + 1;
                end
            end
        end
    end

    // Total occupancy after this edge's pushes and pops
    always_comb begin
        pend_next = '0;
        for (int i = 0; i < int'(FU_NUM); i++) begin
            pend_next = pend_next + PEND_W'(fifo_count[i]) + PEND_W'(push[i]) - PEND_W'(grant[i]);
        end
    end

    // Registered broadcast; invalid lanes keep their stale payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_if.valid         <= '0;
            cdb_if.register_addr <= '0;
            cdb_if.register_val  <= '0;
            cdb_tag              <= '0;
            pending_cnt          <= '0;
        end else begin
            pending_cnt <= pend_next;
            for (int k = 0; k < int'(CDB_LANES); k++) begin
                cdb_if.valid[k] <= lane_vld[k];
                if (lane_vld[k]) begin
                    cdb_if.register_addr[k] <= fifo_head[lane_fu[k]].dst_addr;
                    cdb_if.register_val[k]  <= fifo_head[lane_fu[k]].val;
                    cdb_tag[k]              <= fifo_head[lane_fu[k]].tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 4-FU/2-lane instance carries the main directed
// tests against a per-FU scoreboard; a 4-FU/1-lane instance checks the
// arbitration policy. Tags carry the FU index in their top two bits.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NF = 4;
    localparam int unsigned PW = $clog2(NF * 2 + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Main instance
    logic [NF-1:0]                 a_valid, a_wr, a_ready;
    logic [NF-1:0][PHYS_REG_W-1:0] a_addr;
    logic [NF-1:0][REG_VAL_W-1:0]  a_val;
    logic [NF-1:0][ROB_TAG_W-1:0]  a_tag;
    logic                          a_cdb_ready;
    logic [1:0][ROB_TAG_W-1:0]     a_tag_out;
    logic [PW-1:0]                 a_pend;
    CDB_IF #(.LANES(2)) cdb_a ();

    cdb_arbiter #(.FU_NUM(NF), .CDB_LANES(2), .QUEUE_DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .fu_res_valid     (a_valid),
        .fu_res_reg_write (a_wr),
        .fu_res_dst_addr  (a_addr),
        .fu_res_val       (a_val),
        .fu_res_tag       (a_tag),
        .fu_res_ready     (a_ready),
        .cdb_ready        (a_cdb_ready),
        .cdb_if           (cdb_a),
        .cdb_tag          (a_tag_out),
        .pending_cnt      (a_pend)
    );

    // Single-lane instance for the arbitration policy
    logic [NF-1:0]                 b_valid, b_wr, b_ready;
    logic [NF-1:0][PHYS_REG_W-1:0] b_addr;
    logic [NF-1:0][REG_VAL_W-1:0]  b_val;
    logic [NF-1:0][ROB_TAG_W-1:0]  b_tag;
    logic [0:0][ROB_TAG_W-1:0]     b_tag_out;
    logic [PW-1:0]                 b_pend;
    CDB_IF #(.LANES(1)) cdb_b ();

    cdb_arbiter #(.FU_NUM(NF), .CDB_LANES(1), .QUEUE_DEPTH(2)) dut_b (
        .clk              (clk),
        .reset            (reset),
        .fu_res_valid     (b_valid),
        .fu_res_reg_write (b_wr),
        .fu_res_dst_addr  (b_addr),
        .fu_res_val       (b_val),
        .fu_res_tag       (b_tag),
        .fu_res_ready     (b_ready),
        .cdb_ready        (1'b1),
        .cdb_if           (cdb_b),
        .cdb_tag          (b_tag_out),
        .pending_cnt      (b_pend)
    );

    int total = 0;
    int bad   = 0;

    cdb_result_t exp_q [NF][$];
    cdb_result_t mon_exp;
    logic [1:0]  mon_fu;

    int          b_grants [6];
    int          b_n   = 0;
    logic        b_rec = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic drive(input logic [1:0] f, input logic [PHYS_REG_W-1:0] d_addr,
                         input logic [REG_VAL_W-1:0] d_val, input logic [ROB_TAG_W-1:0] d_tag,
                         input logic wr, input logic expect_bcast);
        a_valid[f] = 1'b1;
        a_wr[f]    = wr;
        a_addr[f]  = d_addr;
        a_val[f]   = d_val;
        a_tag[f]   = d_tag;
        if (expect_bcast) begin
            exp_q[f].push_back('{dst_addr: d_addr, val: d_val, tag: d_tag});
        end
    endtask

    // Scoreboard monitor: every valid lane must match the head of its FU's queue
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (cdb_a.valid[k]) begin
                    mon_fu = a_tag_out[k][ROB_TAG_W-1 -: 2];
                    total++;
                    if (exp_q[mon_fu].size() == 0) begin
                        bad++;
                        $display("FAIL bcast_unexpected lane%0d: got tag=%0h addr=%0h val=%0h required=no broadcast",
                                 k, a_tag_out[k], cdb_a.register_addr[k], cdb_a.register_val[k]);
                    end else begin
                        mon_exp = exp_q[mon_fu].pop_front();
                        if (cdb_a.register_addr[k] !== mon_exp.dst_addr ||
                            cdb_a.register_val[k]  !== mon_exp.val ||
                            a_tag_out[k]           !== mon_exp.tag) begin
                            bad++;
                            $display("FAIL bcast_data lane%0d: got tag=%0h addr=%0h val=%0h required tag=%0h addr=%0h val=%0h",
                                     k, a_tag_out[k], cdb_a.register_addr[k], cdb_a.register_val[k],
                                     mon_exp.tag, mon_exp.dst_addr, mon_exp.val);
                        end
                    end
                end
            end
        end
    end

    // Records the FU granted on the single-lane instance
    always @(negedge clk) begin
        if (reset && b_rec && cdb_b.valid[0] && b_n < 6) begin
            b_grants[b_n] = int'(b_tag_out[0][ROB_TAG_W-1 -: 2]);
            b_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        a_valid = '0; a_wr = '0; a_addr = '0; a_val = '0; a_tag = '0;
        a_cdb_ready = 1'b1;
        b_valid = '0; b_wr = '0; b_addr = '0; b_val = '0; b_tag = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(cdb_a.valid), 64'h0);
        check("rst_ready", 64'(a_ready), 64'hF);
        check("rst_pend",  64'(a_pend), 64'h0);
        check("rst_tag",   64'(a_tag_out), 64'h0);
        check("rst_addr",  64'(cdb_a.register_addr), 64'h0);
        check("rst_val",   64'(cdb_a.register_val), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // Basic broadcast, one cycle after acceptance
        drive(2'd0, 6'd5, 32'hDEAD, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        a_valid = '0;
        check("basic_pend_queued", 64'(a_pend), 64'h1);
        check("basic_not_yet",     64'(cdb_a.valid), 64'h0);
        @(negedge clk);
        check("basic_valid", 64'(cdb_a.valid[0]), 64'h1);
        check("basic_addr",  64'(cdb_a.register_addr[0]), 64'h5);
        check("basic_val",   64'(cdb_a.register_val[0]), 64'hDEAD);
        check("basic_tag",   64'(a_tag_out[0]), 64'h3);
        check("basic_pend0", 64'(a_pend), 64'h0);
        @(negedge clk);
        check("basic_pulse", 64'(cdb_a.valid), 64'h0);

        // Over-subscription: four results, two lanes
        for (int f = 0; f < 4; f++) begin
            drive(2'(f), 6'(10 + f), 32'(32'h100 + f), {2'(f), 3'd1}, 1'b1, 1'b1);
        end
        @(negedge clk);
        a_valid = '0;
        check("over_pend4",  64'(a_pend), 64'h4);
        check("over_lanes0", 64'($countones(cdb_a.valid)), 64'h0);
        @(negedge clk);
        check("over_lanes_c1", 64'($countones(cdb_a.valid)), 64'h2);
        check("over_pend2",    64'(a_pend), 64'h2);
        @(negedge clk);
        check("over_lanes_c2", 64'($countones(cdb_a.valid)), 64'h2);
        check("over_pend0",    64'(a_pend), 64'h0);
        @(negedge clk);
        check("over_idle", 64'(cdb_a.valid), 64'h0);

        // Back-pressure on FU1 with a depth-2 queue
        a_cdb_ready = 1'b0;
        check("bp_ready_empty", 64'(a_ready[1]), 64'h1);
        drive(2'd1, 6'd20, 32'hA1, {2'd1, 3'd2}, 1'b1, 1'b1);
        @(negedge clk);
        check("bp_ready_one", 64'(a_ready[1]), 64'h1);
        drive(2'd1, 6'd21, 32'hA2, {2'd1, 3'd3}, 1'b1, 1'b1);
        @(negedge clk);
        check("bp_ready_full", 64'(a_ready[1]), 64'h0);
        check("bp_pend2",      64'(a_pend), 64'h2);
        drive(2'd1, 6'd22, 32'hA3, {2'd1, 3'd4}, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_stall_ready", 64'(a_ready[1]), 64'h0);
        check("bp_stall_pend",  64'(a_pend), 64'h2);
        check("bp_no_bcast",    64'(cdb_a.valid), 64'h0);
        a_cdb_ready = 1'b1;
        @(negedge clk);
        check("bp_reopen", 64'(a_ready[1]), 64'h1);
        check("bp_tag1",   64'(a_tag_out[0]), 64'({2'd1, 3'd2}));
        check("bp_pend1",  64'(a_pend), 64'h1);
        exp_q[1].push_back('{dst_addr: 6'd22, val: 32'hA3, tag: {2'd1, 3'd4}});
        @(negedge clk);
        a_valid = '0;
        check("bp_tag2",       64'(a_tag_out[0]), 64'({2'd1, 3'd3}));
        check("bp_pend_swap",  64'(a_pend), 64'h1);
        @(negedge clk);
        check("bp_tag3",  64'(a_tag_out[0]), 64'({2'd1, 3'd4}));
        check("bp_drain", 64'(a_pend), 64'h0);
        @(negedge clk);
        check("bp_idle", 64'(cdb_a.valid), 64'h0);

        // Non-writing results: acknowledged, never broadcast
        drive(2'd2, 6'd30, 32'hBEEF, {2'd2, 3'd5}, 1'b0, 1'b0);
        check("nw_ready", 64'(a_ready[2]), 64'h1);
        @(negedge clk);
        check("nw_pend_a",  64'(a_pend), 64'h0);
        check("nw_ready_a", 64'(a_ready[2]), 64'h1);
        @(negedge clk);
        a_valid = '0;
        a_wr    = '0;
        check("nw_pend_b",  64'(a_pend), 64'h0);
        check("nw_lanes_b", 64'(cdb_a.valid), 64'h0);
        @(negedge clk);
        check("nw_lanes_c", 64'(cdb_a.valid), 64'h0);

        // Reset mid-operation with one result still queued
        a_cdb_ready = 1'b0;
        drive(2'd0, 6'd40, 32'h40, {2'd0, 3'd6}, 1'b1, 1'b1);
        drive(2'd1, 6'd41, 32'h41, {2'd1, 3'd6}, 1'b1, 1'b1);
        @(negedge clk);
        a_valid[1] = 1'b0;
        drive(2'd0, 6'd42, 32'h42, {2'd0, 3'd7}, 1'b1, 1'b0);
        @(negedge clk);
        a_valid = '0;
        check("mid_pend3", 64'(a_pend), 64'h3);
        a_cdb_ready = 1'b1;
        @(negedge clk);
        check("mid_lanes", 64'($countones(cdb_a.valid)), 64'h2);
        check("mid_pend1", 64'(a_pend), 64'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(cdb_a.valid), 64'h0);
        check("mid_rst_pend",  64'(a_pend), 64'h0);
        check("mid_rst_ready", 64'(a_ready), 64'hF);
        check("mid_rst_tag",   64'(a_tag_out), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid_after_release", 64'(cdb_a.valid), 64'h0);
        end

        // Arbitration policy on the single-lane instance
        b_wr      = '1;
        b_addr[0] = 6'd1;  b_val[0] = 32'h10; b_tag[0] = {2'd0, 3'd0};
        b_addr[2] = 6'd3;  b_val[2] = 32'h30; b_tag[2] = {2'd2, 3'd0};
        b_valid   = 4'b0101;
        b_rec     = 1'b1;
        for (int c = 0; c < 30 && b_n < 6; c++) begin
            @(negedge clk);
        end
        b_valid = '0;
        b_rec   = 1'b0;
        check("policy_grant_count", 64'(b_n), 64'h6);
        for (int i = 0; i < 6; i++) begin
            if (i < b_n) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
                check("policy_grant", 64'(b_grants[i]), (i % 2 == 0) ? 64'h0 : 64'h2);
`else
                check("policy_grant", 64'(b_grants[i]), 64'h0);
`endif
            end
        end
        repeat (6) @(negedge clk);
        check("policy_drain_pend",  64'(b_pend), 64'h0);
        check("policy_drain_ready", 64'(b_ready), 64'hF);

        // Every expected broadcast must have been seen
        for (int f = 0; f < 4; f++) begin
            check("sb_leftover", 64'(exp_q[f].size()), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
